branch_link_ctrl: RTL and testbench

- Sequencer for the conditional-branch-and-link path (BLTZAL/BGEZAL class) in the P5 pipelined MIPS core.
- Takes the ID-stage branch decode and the 1-bit condition result, drives the NPC select, and stalls ID while the condition operand is not yet forwarded.
- Tracks the delay slot.
- Carries the $31 link write down a LINK_LAT-deep token pipeline to the WB register-file port.

---
 rtl/branch_link_ctrl.sv | 134 +++++++++++++
 tb/tb_branch_link_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_link_ctrl.sv
// Branch-and-link sequencer: condition wait, NPC select, delay-slot tracking and link token pipe.
// Optional BRLINK_COUNT_EN adds taken_cnt/link_cnt event counters.
module branch_link_ctrl #(
    parameter int LINK_LAT = 3,
    parameter int LINK_REG = 31,
    parameter int AW       = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          freeze,
    input  logic          br_valid,
    input  logic          br_link,
    input  logic          cond_valid,
    input  logic          br_cond,
    input  logic [AW-1:0] id_pc,
    output logic          stall_out,
    output logic          npc_sel,
    output logic          link_we,
    output logic [4:0]    link_waddr,
    output logic [AW-1:0] link_wdata,
`ifdef BRLINK_COUNT_EN
    output logic [15:0]   taken_cnt,
    output logic [15:0]   link_cnt,
`endif
    output logic          dslot_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DSLOT = 2'd2
    } state_e;

    localparam logic [AW-1:0] PC_OFS = AW'(8);

    state_e state_q, state_d;
    logic   resolve;

    logic [LINK_LAT-1:0] vld_q;
    logic [AW-1:0]       dat_q [LINK_LAT];
    logic [AW-1:0]       link_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stall_out = 1'b0;
        resolve   = 1'b0;
        dslot_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (br_valid) begin
                    if (cond_valid) begin
                        resolve = 1'b1;
                        state_d = S_DSLOT;
                    end else begin
                        stall_out = 1'b1;
                        state_d   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cond_valid) begin
                    resolve = 1'b1;
                    state_d = S_DSLOT;
                end else begin
                    stall_out = 1'b1;
                end
            end
            S_DSLOT: begin
                dslot_err = br_valid;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A frozen cycle must not resolve; the branch retries once unfrozen
        if (freeze) begin
            state_d   = state_q;
            resolve   = 1'b0;
            dslot_err = 1'b0;
        end
    end

    assign npc_sel = resolve & br_cond;
    assign link_d  = id_pc + PC_OFS;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LINK_LAT; i++) begin
                dat_q[i] <= '0;
            end
        end else if (!freeze) begin
            for (int i = LINK_LAT - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
            vld_q[0] <= resolve & br_link;
            dat_q[0] <= resolve ? link_d : '0;
        end
    end

    assign link_we    = vld_q[LINK_LAT-1];
    assign link_waddr = link_we ? 5'(LINK_REG) : 5'd0;
    assign link_wdata = dat_q[LINK_LAT-1];

`ifdef BRLINK_COUNT_EN
    logic [15:0] taken_q, lcnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q <= '0;
            lcnt_q  <= '0;
        end else if (!freeze) begin
            if (npc_sel && taken_q != 16'hFFFF) begin
                taken_q <= taken_q + 16'd1;
            end
            if (link_we && lcnt_q != 16'hFFFF) begin
                lcnt_q <= lcnt_q + 16'd1;
            end
        end
    end

    assign taken_cnt = taken_q;
    assign link_cnt  = lcnt_q;
`endif

endmodule

// File: tb/tb_branch_link_ctrl.sv
// Directed bench for branch_link_ctrl with LINK_LAT=3, AW=32.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_branch_link_ctrl;

    logic        clk;
    logic        rst_n;
    logic        freeze;
    logic        br_valid;
    logic        br_link;
    logic        cond_valid;
    logic        br_cond;
    logic [31:0] id_pc;
    logic        stall_out;
    logic        npc_sel;
    logic        link_we;
    logic [4:0]  link_waddr;
    logic [31:0] link_wdata;
    logic        dslot_err;
`ifdef BRLINK_COUNT_EN
    logic [15:0] taken_cnt;
    logic [15:0] link_cnt;
`endif

    int n_chk;
    int n_fail;

    branch_link_ctrl #(
        .LINK_LAT(3),
        .LINK_REG(31),
        .AW(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .freeze(freeze),
        .br_valid(br_valid),
        .br_link(br_link),
        .cond_valid(cond_valid),
        .br_cond(br_cond),
        .id_pc(id_pc),
        .stall_out(stall_out),
        .npc_sel(npc_sel),
        .link_we(link_we),
        .link_waddr(link_waddr),
        .link_wdata(link_wdata),
`ifdef BRLINK_COUNT_EN
        .taken_cnt(taken_cnt),
        .link_cnt(link_cnt),
`endif
        .dslot_err(dslot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic bv, input logic bl, input logic cv,
                         input logic bc, input logic [31:0] pc,
                         input logic fz);
        br_valid   = bv;
        br_link    = bl;
        cond_valid = cv;
        br_cond    = bc;
        id_pc      = pc;
        freeze     = fz;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    // Expects the link write in the current cycle
    task automatic chk_link(input string tag, input logic we,
                            input logic [31:0] data);
        check_eq({tag, "_we"}, 64'(link_we), 64'(we));
        check_eq({tag, "_waddr"}, 64'(link_waddr), we ? 64'd31 : 64'd0);
        if (we) check_eq({tag, "_wdata"}, 64'(link_wdata), 64'(data));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("rst_stall", 64'(stall_out), 64'd0);
        check_eq("rst_npc", 64'(npc_sel), 64'd0);
        check_eq("rst_dslot", 64'(dslot_err), 64'd0);
        chk_link("rst", 1'b0, 32'h0);
        check_eq("rst_wdata", 64'(link_wdata), 64'd0);
        next();
        next();
        rst_n = 1'b1;
        next();

        // Taken link
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 1'b0);
        check_eq("tk_npc", 64'(npc_sel), 64'd1);
        check_eq("tk_stall", 64'(stall_out), 64'd0);
        next(); idle();
        check_eq("tk_dslot", 64'(dslot_err), 64'd0);
        chk_link("tk_c1", 1'b0, 32'h0);
        next(); idle(); chk_link("tk_c2", 1'b0, 32'h0);
        next(); idle(); chk_link("tk_c3", 1'b1, 32'h0000_3008);
        next(); idle(); chk_link("tk_c4", 1'b0, 32'h0);

        // Not-taken link still writes $31
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_3000, 1'b0);
        check_eq("nt_npc", 64'(npc_sel), 64'd0);
        next(); idle();
        next(); idle();
        next(); idle(); chk_link("nt_c3", 1'b1, 32'h0000_3008);
        next(); idle();

        // Operand not ready for two cycles
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 1'b0);
        check_eq("wt_stall0", 64'(stall_out), 64'd1);
        check_eq("wt_npc0", 64'(npc_sel), 64'd0);
        next();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 1'b0);
        check_eq("wt_stall1", 64'(stall_out), 64'd1);
        next();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1000, 1'b0);
        check_eq("wt_stall2", 64'(stall_out), 64'd0);
        check_eq("wt_npc2", 64'(npc_sel), 64'd1);
        next(); idle();
        next(); idle(); chk_link("wt_c4", 1'b0, 32'h0);
        next(); idle(); chk_link("wt_c5", 1'b1, 32'h0000_1008);
        next(); idle();

        // Branch sitting in the delay slot
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 1'b0);
        next();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3004, 1'b0);
        check_eq("ds_err1", 64'(dslot_err), 64'd1);
        check_eq("ds_npc1", 64'(npc_sel), 64'd0);
        next(); idle();
        check_eq("ds_err2", 64'(dslot_err), 64'd0);
        next(); idle(); chk_link("ds_c3", 1'b1, 32'h0000_3008);
        next(); idle(); chk_link("ds_c4", 1'b0, 32'h0);
        next(); idle(); chk_link("ds_c5", 1'b0, 32'h0);

        // Freeze for cycles 1-2 after a resolve
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_5000, 1'b0);
        next();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_5004, 1'b1);
        check_eq("fz_npc1", 64'(npc_sel), 64'd0);
        check_eq("fz_err1", 64'(dslot_err), 64'd0);
        next();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_5004, 1'b1);
        check_eq("fz_npc2", 64'(npc_sel), 64'd0);
        next(); idle(); chk_link("fz_c3", 1'b0, 32'h0);
        next(); idle(); chk_link("fz_c4", 1'b0, 32'h0);
        next(); idle(); chk_link("fz_c5", 1'b1, 32'h0000_5008);
        next(); idle(); chk_link("fz_c6", 1'b0, 32'h0);

        // Freeze beats a simultaneous resolve in IDLE
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_6000, 1'b1);
        check_eq("fzr_npc0", 64'(npc_sel), 64'd0);
        next();
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_6000, 1'b0);
        check_eq("fzr_npc1", 64'(npc_sel), 64'd1);
        next(); idle();
        next(); idle();
        next(); idle(); chk_link("fzr_c4", 1'b1, 32'h0000_6008);
        next(); idle();

        // br_link=0 resolves without a link write
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_7000, 1'b0);
        check_eq("nl_npc", 64'(npc_sel), 64'd1);
        next(); idle();
        next(); idle();
        next(); idle(); chk_link("nl_c3", 1'b0, 32'h0);
        next(); idle();

        // Reset mid-flight
        drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_8000, 1'b0);
        next(); idle();
        rst_n = 1'b0;
        #1;
        chk_link("mr_now", 1'b0, 32'h0);
        check_eq("mr_npc", 64'(npc_sel), 64'd0);
        check_eq("mr_stall", 64'(stall_out), 64'd0);
        next();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            next(); idle();
            chk_link("mr_after", 1'b0, 32'h0);
        end

        // PC wrap-around
        drive(1'b1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0);
        next(); idle();
        next(); idle();
        next(); idle(); chk_link("wrap_c3", 1'b1, 32'h0000_0004);
        next(); idle();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
